// File: rtl/spi_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared FSM state encoding, owner codes and round-robin codes
//               for the two-master configuration-flash SPI arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  // Encoding presented on the owner output
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  // Round-robin "last granted" pointer values
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_flash_arbiter
// Description : Shares the configuration-flash SPI pins between two masters.
//               Grants whole chip-select transactions, round-robin on ties,
//               and holds flash_csel high for GUARD_CYCLES between owners.
//               Optional forced revoke of a stuck owner is built when the
//               macro SPI_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_a,
  output logic       gnt_a,
  input  logic       csel_a,
  input  logic       sclk_a,
  input  logic       mosi_a,
  input  logic       req_b,
  output logic       gnt_b,
  input  logic       csel_b,
  input  logic       sclk_b,
  input  logic       mosi_b,
  output logic       miso_out,
  output logic       flash_csel,
  output logic       flash_sclk,
  output logic       flash_mosi,
  input  logic       flash_miso,
  output logic [1:0] owner,
  output logic       timeout_err
);

  // Reject out-of-range configurations at elaboration time
  generate
    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("spi_flash_arbiter: GUARD_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 2");
    end
  endgenerate

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] guard_q, guard_d;

  logic       w_req_a_eff;
  logic       w_req_b_eff;
  logic       w_rel_a;
  logic       w_rel_b;
  logic       w_timeout_hit;

  // An owner lets go only when it has stopped requesting and its CS is high,
  // so a transaction in flight is never cut short by an early req drop.
  assign w_rel_a = !req_a && csel_a;
  assign w_rel_b = !req_b && csel_b;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
  logic            blk_a_q, blk_a_d;
  logic            blk_b_q, blk_b_d;
  logic            w_revoke_a;
  logic            w_revoke_b;

  assign w_timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_revoke_a    = (state_q == ST_OWN_A) && !w_rel_a && w_timeout_hit;
  assign w_revoke_b    = (state_q == ST_OWN_B) && !w_rel_b && w_timeout_hit;
  // A revoked port is ignored until it has dropped req at least once
  assign w_req_a_eff   = req_a && !blk_a_q;
  assign w_req_b_eff   = req_b && !blk_b_q;
  assign timeout_err   = to_err_q;

  // Owned-cycle counter, revoke pulse and per-port re-request lockout
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_OWN_A || state_q == ST_OWN_B) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    to_err_d = w_revoke_a || w_revoke_b;
    blk_a_d  = blk_a_q;
    blk_b_d  = blk_b_q;
    if (w_revoke_a)  blk_a_d = 1'b1;
    else if (!req_a) blk_a_d = 1'b0;
    if (w_revoke_b)  blk_b_d = 1'b1;
    else if (!req_b) blk_b_d = 1'b0;
  end

  // Timeout bookkeeping registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
      blk_a_q  <= 1'b0;
      blk_b_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
      blk_a_q  <= blk_a_d;
      blk_b_q  <= blk_b_d;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_req_a_eff   = req_a;
  assign w_req_b_eff   = req_b;
  assign timeout_err   = 1'b0;
`endif

  // Next-state logic: arbitration, release detection and guard countdown
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    guard_d = guard_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req_a_eff && w_req_b_eff) begin
          if (last_q == LAST_A) begin
            state_d = ST_OWN_B;
            last_d  = LAST_B;
          end else begin
            state_d = ST_OWN_A;
            last_d  = LAST_A;
          end
        end else if (w_req_a_eff) begin
          state_d = ST_OWN_A;
          last_d  = LAST_A;
        end else if (w_req_b_eff) begin
          state_d = ST_OWN_B;
          last_d  = LAST_B;
        end
      end
      ST_OWN_A: begin
        if (w_rel_a || w_timeout_hit) begin
          state_d = ST_GUARD;
          guard_d = 8'(GUARD_CYCLES - 1);
        end
      end
      ST_OWN_B: begin
        if (w_rel_b || w_timeout_hit) begin
          state_d = ST_GUARD;
          guard_d = 8'(GUARD_CYCLES - 1);
        end
      end
      ST_GUARD: begin
        if (guard_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, round-robin pointer and guard counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_B;
      guard_q <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      guard_q <= guard_d;
    end
  end

  // Pin mux and status decode, driven from registered state so an async
  // reset parks the flash pins immediately
  always_comb begin
    flash_csel = 1'b1;
    flash_sclk = 1'b0;
    flash_mosi = 1'b0;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    owner      = OWNER_NONE;
    case (state_q)
      ST_OWN_A: begin
        flash_csel = csel_a;
        flash_sclk = sclk_a;
        flash_mosi = mosi_a;
        gnt_a      = 1'b1;
        owner      = OWNER_A;
      end
      ST_OWN_B: begin
        flash_csel = csel_b;
        flash_sclk = sclk_b;
        flash_mosi = mosi_b;
        gnt_b      = 1'b1;
        owner      = OWNER_B;
      end
      default: begin
        flash_csel = 1'b1;
      end
    endcase
  end

  assign miso_out = flash_miso;

  // Both grants must never be high together
  a_gnt_onehot: assert property (@(posedge clk) !(gnt_a && gnt_b));

endmodule : spi_flash_arbiter
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_arbiter
// Description : Self-checking bench for spi_flash_arbiter. Each scenario is a
//               table of per-cycle input vectors and expected output vectors;
//               expectations go into a scoreboard queue when the inputs are
//               driven and are popped and compared mid-cycle.
//               Run with SPI_ARB_TIMEOUT_EN defined to cover the timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;
  import spi_arb_pkg::*;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`else
  localparam int TB_TIMEOUT = 1048576;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_a = 1'b0, csel_a = 1'b1, sclk_a = 1'b0, mosi_a = 1'b0;
  logic       req_b = 1'b0, csel_b = 1'b1, sclk_b = 1'b0, mosi_b = 1'b0;
  logic       gnt_a, gnt_b, miso_out, flash_csel, flash_sclk, flash_mosi;
  logic       flash_miso = 1'b0;
  logic [1:0] owner;
  logic       timeout_err;

  spi_flash_arbiter #(
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_a       (req_a),
    .gnt_a       (gnt_a),
    .csel_a      (csel_a),
    .sclk_a      (sclk_a),
    .mosi_a      (mosi_a),
    .req_b       (req_b),
    .gnt_b       (gnt_b),
    .csel_b      (csel_b),
    .sclk_b      (sclk_b),
    .mosi_b      (mosi_b),
    .miso_out    (miso_out),
    .flash_csel  (flash_csel),
    .flash_sclk  (flash_sclk),
    .flash_mosi  (flash_mosi),
    .flash_miso  (flash_miso),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Observed vector: {owner[1:0], gnt_a, gnt_b, flash_csel, flash_sclk, flash_mosi, timeout_err}
  logic [7:0] act;
  assign act = {owner, gnt_a, gnt_b, flash_csel, flash_sclk, flash_mosi, timeout_err};

  // Stimulus vector: {req_a, csel_a, sclk_a, mosi_a, req_b, csel_b, sclk_b, mosi_b}
  typedef struct packed {
    logic [7:0] stim;
    logic [7:0] exp;
  } row_t;

  row_t       rows[$];
  logic [7:0] sb_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic add(input logic [7:0] s, input logic [7:0] e, input int n);
    row_t r;
    r.stim = s;
    r.exp  = e;
    for (int k = 0; k < n; k++) rows.push_back(r);
  endtask

  task automatic apply(input logic [7:0] s);
    {req_a, csel_a, sclk_a, mosi_a, req_b, csel_b, sclk_b, mosi_b} = s;
  endtask

  task automatic do_reset();
    apply(8'h44);
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    apply(8'h44);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    e = 8'h08;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", act, e);
    end
    flash_miso = 1'b1;
    #1;
    total++;
    if (miso_out !== 1'b1) begin
      bad++;
      $display("FAIL miso_high: got %b want 1", miso_out);
    end
    flash_miso = 1'b0;
    #1;
    total++;
    if (miso_out !== 1'b0) begin
      bad++;
      $display("FAIL miso_low: got %b want 0", miso_out);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_port_a_only();
    logic [7:0] got, e;
    rows.delete();
    add(8'hC4, 8'h08, 1); add(8'hB4, 8'h66, 1); add(8'h84, 8'h60, 1);
    add(8'h44, 8'h68, 1); add(8'h4C, 8'h08, 5); add(8'h4C, 8'h98, 1);
    add(8'h4A, 8'h94, 1); add(8'h44, 8'h98, 1); add(8'h44, 8'h08, 6);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL port_a_only step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got, e;
    do_reset();
    rows.delete();
    add(8'hCC, 8'h08, 1); add(8'hCC, 8'h68, 1); add(8'h4C, 8'h68, 1);
    add(8'h4C, 8'h08, 5); add(8'h4C, 8'h98, 1); add(8'hC4, 8'h98, 1);
    add(8'hCC, 8'h08, 5); add(8'hCC, 8'h68, 1); add(8'h4C, 8'h68, 1);
    add(8'hCC, 8'h08, 5); add(8'hCC, 8'h98, 1); add(8'hC4, 8'h98, 1);
    add(8'hC4, 8'h08, 5); add(8'hC4, 8'h68, 1); add(8'h44, 8'h68, 1);
    add(8'h44, 8'h08, 6);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL round_robin step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_hold_until_csel();
    logic [7:0] got, e;
    rows.delete();
    add(8'hC4, 8'h08, 1); add(8'h84, 8'h60, 1); add(8'h0C, 8'h60, 10);
    add(8'h4C, 8'h68, 1); add(8'h4C, 8'h08, 5); add(8'h4C, 8'h98, 1);
    add(8'h44, 8'h98, 1); add(8'h44, 8'h08, 6);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL hold_until_csel step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_isolation();
    logic [7:0] got, e;
    rows.delete();
    add(8'hC4, 8'h08, 1); add(8'h83, 8'h60, 1); add(8'hA1, 8'h64, 1);
    add(8'h92, 8'h62, 1); add(8'h43, 8'h68, 1); add(8'h43, 8'h08, 4);
    add(8'h44, 8'h08, 2);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL isolation step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got, e;
    rows.delete();
    add(8'hC4, 8'h08, 1); add(8'h84, 8'h60, 1);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL async_pre step %0d: got %h want %h", i, got, e);
      end
    end
    // Mid-cycle reset with A still driving csel low: outputs drop at once
    #1;
    resetn = 1'b0;
    sb_q.push_back(8'h08);
    #1;
    got = act;
    e   = sb_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async_reset_immediate: got %h want %h", got, e);
    end
    apply(8'h44);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    rows.delete();
    add(8'hCC, 8'h08, 1); add(8'hCC, 8'h68, 1); add(8'h44, 8'h68, 1);
    add(8'h44, 8'h08, 6);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL async_post step %0d: got %h want %h", i, got, e);
      end
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] got, e;
    rows.delete();
    add(8'hC4, 8'h08, 1); add(8'h8C, 8'h60, 16); add(8'h8C, 8'h09, 1);
    add(8'h8C, 8'h08, 4); add(8'h8C, 8'h98, 1); add(8'hC4, 8'h98, 1);
    add(8'hC4, 8'h08, 6); add(8'h44, 8'h08, 1); add(8'hC4, 8'h08, 1);
    add(8'hC4, 8'h68, 1); add(8'h44, 8'h68, 1); add(8'h44, 8'h08, 6);
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      apply(rows[i].stim);
      sb_q.push_back(rows[i].exp);
      #2;
      got = act;
      e   = sb_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL timeout step %0d: got %h want %h", i, got, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_port_a_only();
    test_round_robin();
    test_hold_until_csel();
    test_isolation();
    test_async_reset();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_flash_arbiter
`default_nettype wire
